// File: rtl/reg_alu_datapath.sv
// Multi-cycle register-file/ALU datapath: IDLE -> READ -> EXEC -> WRITE, one instruction per handshake.
// Define ALU_FLAGS_EN to add the wb_carry/wb_ovf outputs for ADD/SUB.
module reg_alu_datapath #(
  parameter int DATA_W = 32,
  parameter int NREG   = 8,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  input  logic [RA_W-1:0]   instr_rd,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              illegal,
`ifdef ALU_FLAGS_EN
  output logic              wb_carry,
  output logic              wb_ovf,
`endif
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [RA_W-1:0]   rs1_q, rs2_q, rd_q;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] regs [NREG];
  logic              op_illegal;
  logic [SH_W-1:0]   shamt;

  // Opcodes 12-15 are reserved; they retire without touching the register file.
  assign op_illegal = (op_q[3:2] == 2'b11);
  assign shamt      = opb[SH_W-1:0];
  assign dbg_data   = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        wb_valid  = !op_illegal;
        illegal   = op_illegal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      4'd0:  alu_res = opa + opb;
      4'd1:  alu_res = opa - opb;
      4'd2:  alu_res = opa & opb;
      4'd3:  alu_res = opa | opb;
      4'd4:  alu_res = opa ^ opb;
      4'd5:  alu_res = ~opa;
      4'd6:  alu_res = opa << shamt;
      4'd7:  alu_res = opa >> shamt;
      4'd8:  alu_res = DATA_W'($signed(opa) >>> shamt);
      4'd9:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd10: alu_res = {{(DATA_W-1){1'b0}}, (opa < opb)};
      4'd11: alu_res = opb;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] add_ext, sub_ext;
  logic            carry_nxt, ovf_nxt;

  // The extra top bit of each widened sum is the carry-out (ADD) or borrow (SUB).
  always_comb begin
    add_ext   = {1'b0, opa} + {1'b0, opb};
    sub_ext   = {1'b0, opa} - {1'b0, opb};
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    case (op_q)
      4'd0: begin
        carry_nxt = add_ext[DATA_W];
        ovf_nxt   = (opa[DATA_W-1] == opb[DATA_W-1]) && (add_ext[DATA_W-1] != opa[DATA_W-1]);
      end
      4'd1: begin
        carry_nxt = sub_ext[DATA_W];
        ovf_nxt   = (opa[DATA_W-1] != opb[DATA_W-1]) && (sub_ext[DATA_W-1] != opa[DATA_W-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_carry <= 1'b0;
      wb_ovf   <= 1'b0;
    end else if (state == EXEC && !op_illegal) begin
      wb_carry <= carry_nxt;
      wb_ovf   <= ovf_nxt;
    end
  end
`endif

  // The writeback registers double as the EXEC result register, so they hold between writebacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      opa     <= '0;
      opb     <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
      wb_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          op_q  <= instr_op;
          rs1_q <= instr_rs1;
          rs2_q <= instr_rs2;
          rd_q  <= instr_rd;
        end
        READ: begin
          opa <= regs[rs1_q];
          opb <= regs[rs2_q];
        end
        EXEC: if (!op_illegal) begin
          wb_rd   <= rd_q;
          wb_data <= alu_res;
          wb_zero <= (alu_res == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == WRITE && !op_illegal) begin
      regs[rd_q] <= wb_data;
    end
  end

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Self-checking bench for reg_alu_datapath: directed constant-building sequence, back-to-back,
// illegal opcode, mid-operation reset and randomized instructions against an arithmetic model.
module tb_reg_alu_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [2:0]  instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`ifdef ALU_FLAGS_EN
  logic        wb_carry, wb_ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model [8];
  logic [31:0] last_data;
  logic [2:0]  last_rd;
  logic        last_zero;
  logic        last_carry, last_ovf;

  reg_alu_datapath #(.DATA_W(32), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
    .illegal(illegal),
`ifdef ALU_FLAGS_EN
    .wb_carry(wb_carry), .wb_ovf(wb_ovf),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the opcode table with plain arithmetic.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd9:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] refFlags(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic c;
    if (op == 4'd0) begin
      c = ((longint'(a) + longint'(b)) > 64'sd4294967295);
      s = longint'(int'(a)) + longint'(int'(b));
    end else if (op == 4'd1) begin
      c = (a < b);
      s = longint'(int'(a)) - longint'(int'(b));
    end else begin
      return 2'b00;
    end
    return {c, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) model[i] = '0;
    last_data = '0; last_rd = '0; last_zero = 1'b0; last_carry = 1'b0; last_ovf = 1'b0;
  endtask

  // One complete instruction with cycle-by-cycle checks; inputs are garbage-driven while busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd);
    logic [31:0] exp_res, old_rd;
    logic [1:0]  exp_fl;
    logic        legal;
    @(negedge clk);
    checkOutput("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    legal   = (op < 4'd12);
    exp_res = refAlu(op, model[rs1], model[rs2]);
    exp_fl  = refFlags(op, model[rs1], model[rs2]);
    old_rd  = model[rd];
    @(posedge clk); #1;
    instr_op = 4'(($urandom_range(0, 15))); instr_rd = 3'($urandom_range(0, 7));
    instr_rs1 = 3'($urandom_range(0, 7)); instr_rs2 = 3'($urandom_range(0, 7));
    @(negedge clk);
    checkOutput("ready_read", 32'(instr_ready), 32'd0);
    checkOutput("wbv_read", 32'(wb_valid), 32'd0);
    @(negedge clk);
    checkOutput("wbv_exec", 32'(wb_valid | illegal), 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("wb_valid", 32'(wb_valid), 32'(legal));
    checkOutput("illegal", 32'(illegal), 32'(!legal));
    checkOutput("ready_write", 32'(instr_ready), 32'd0);
    if (legal) begin
      last_data = exp_res; last_rd = rd; last_zero = (exp_res == 32'd0);
      {last_carry, last_ovf} = exp_fl;
    end
    checkOutput("wb_data", wb_data, last_data);
    checkOutput("wb_rd", 32'(wb_rd), 32'(last_rd));
    checkOutput("wb_zero", 32'(wb_zero), 32'(last_zero));
`ifdef ALU_FLAGS_EN
    checkOutput("wb_carry", 32'(wb_carry), 32'(last_carry));
    checkOutput("wb_ovf", 32'(wb_ovf), 32'(last_ovf));
`endif
    dbg_addr = rd; #1;
    checkOutput("dbg_prewrite", dbg_data, old_rd);
    if (legal) model[rd] = exp_res;
    @(negedge clk);
    checkOutput("ready_back", 32'(instr_ready), 32'd1);
    checkOutput("pulse_end", 32'(wb_valid | illegal), 32'd0);
    checkOutput("dbg_postwrite", dbg_data, model[rd]);
    checkOutput("wb_data_hold", wb_data, last_data);
  endtask

  task automatic dbgSweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checkOutput(tag, dbg_data, model[i]);
    end
  endtask

  initial begin
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_wb", {wb_data[31:3], wb_rd} | 32'(wb_valid) | 32'(illegal) | 32'(wb_zero), 32'd0);
    rst = 1'b1;
    dbgSweep("rst_dbg");

    // Build R1=5, R2=3 from all-zero registers.
    applyStimulus(4'd5, 3'd0, 3'd0, 3'd7);   // R7 = ~0
    applyStimulus(4'd1, 3'd0, 3'd7, 3'd1);   // R1 = 1
    applyStimulus(4'd0, 3'd1, 3'd1, 3'd2);   // R2 = 2
    applyStimulus(4'd0, 3'd2, 3'd2, 3'd4);   // R4 = 4
    applyStimulus(4'd0, 3'd2, 3'd1, 3'd2);   // R2 = 3
    applyStimulus(4'd0, 3'd4, 3'd1, 3'd1);   // R1 = 5
    applyStimulus(4'd0, 3'd1, 3'd2, 3'd3);   // R3 = 8
    checkOutput("add_5_3", wb_data, 32'd8);
    applyStimulus(4'd1, 3'd1, 3'd1, 3'd4);
    checkOutput("sub_zero", 32'(wb_zero), 32'd1);
    applyStimulus(4'd1, 3'd0, 3'd7, 3'd6);   // R6 = 1
    applyStimulus(4'd9, 3'd7, 3'd6, 3'd5);
    checkOutput("slt_neg", wb_data, 32'd1);
    applyStimulus(4'd10, 3'd7, 3'd6, 3'd5);
    checkOutput("sltu_big", wb_data, 32'd0);
    applyStimulus(4'd7, 3'd7, 3'd6, 3'd5);   // R5 = 0x7FFFFFFF
    applyStimulus(4'd5, 3'd5, 3'd0, 3'd5);   // R5 = 0x80000000
    applyStimulus(4'd0, 3'd2, 3'd6, 3'd4);   // R4 = 4
    applyStimulus(4'd8, 3'd5, 3'd4, 3'd0);
    checkOutput("sra_msb", wb_data, 32'hF800_0000);

    // Back-to-back dependent pair with instr_valid held high: R5=R3+R3, R6=R5+R5.
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd0; instr_rs1 = 3'd3; instr_rs2 = 3'd3; instr_rd = 3'd5;
    @(posedge clk); #1;
    instr_rs1 = 3'd5; instr_rs2 = 3'd5; instr_rd = 3'd6;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("b2b_ready", 32'(instr_ready), (c % 4 == 3) ? 32'd1 : 32'd0);
      if (c == 2) checkOutput("b2b_first", wb_data, 32'd16);
      if (c == 6) checkOutput("b2b_second", wb_data, 32'd32);
      if (c == 4) instr_valid = 1'b0;
    end
    model[5] = 32'd16; model[6] = 32'd32;
    last_data = 32'd32; last_rd = 3'd6; last_zero = 1'b0;
    dbg_addr = 3'd6; #1;
    checkOutput("b2b_r6", dbg_data, 32'd32);

    applyStimulus(4'd13, 3'd1, 3'd2, 3'd3);
    checkOutput("illegal_keep", model[3], 32'd8);

    for (int n = 0; n < 40; n++)
      applyStimulus(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    dbgSweep("rand_dbg");

    // Abort an instruction in EXEC with reset.
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd5; instr_rs1 = 3'd0; instr_rd = 3'd2;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    clearModel();
    checkOutput("abort_ready", 32'(instr_ready), 32'd1);
    checkOutput("abort_wbv", 32'(wb_valid), 32'd0);
    checkOutput("abort_data", wb_data, 32'd0);
    dbgSweep("abort_dbg");
    @(negedge clk);
    checkOutput("abort_nowb", 32'(wb_valid), 32'd0);
    rst = 1'b1;

`ifdef ALU_FLAGS_EN
    applyStimulus(4'd5, 3'd0, 3'd0, 3'd7);
    applyStimulus(4'd1, 3'd0, 3'd7, 3'd1);
    applyStimulus(4'd7, 3'd7, 3'd1, 3'd2);
    applyStimulus(4'd0, 3'd2, 3'd1, 3'd3);
    checkOutput("ovf_set", 32'(wb_ovf), 32'd1);
    checkOutput("carry_clr", 32'(wb_carry), 32'd0);
`else
    applyStimulus(4'd5, 3'd0, 3'd0, 3'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
